// File: rtl/types_def.sv
// Shared front-end/back-end types: request kind, read data width and
// read index width (log2 of reorder depth).
package types_def;

   localparam int unsigned data_width       = 32;
   localparam int unsigned read_entries_log = 3;

   typedef enum logic {
      read  = 1'b0,
      write = 1'b1
   } r_type;

endpackage : types_def

// File: rtl/returner_buffer.sv
// Reorder storage for returner: DEPTH x DATA_WIDTH data array with one
// synchronous write port, one asynchronous read port at head, plus the
// per-slot occupancy vector.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (clears occ only)
//   wr_en        store wr_data at wr_idx and mark the slot occupied
//   wr_idx       slot written
//   wr_data      data written
//   clr_en       free the slot at head (dequeue)
//   head         head pointer for read port and clear
//   head_data    data stored at head
//   occ          occupancy vector, one bit per slot
module returner_buffer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_W      = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    clr_en,
   input  logic [IDX_W-1:0]        head,
   output logic [DATA_WIDTH-1:0]   head_data,
   output logic [(2**IDX_W)-1:0]   occ
);

   localparam int unsigned DEPTH = 2**IDX_W;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Data storage is intentionally not reset; occ qualifies it.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   // Clear and set never target the same slot in one cycle: a set needs a
   // free slot, a clear needs an occupied one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ <= '0;
      end else begin
         if (clr_en) occ[head]   <= 1'b0;
         if (wr_en)  occ[wr_idx] <= 1'b1;
      end
   end

   assign head_data = mem[head];

endmodule : returner_buffer

// File: rtl/returner.sv
// Collects completed requests from burst_handler. Writes are acknowledged
// with a one-cycle wr_done pulse; reads are reordered by index and released
// in ascending index order over a valid/ready handshake.
// Optional feature macro: RETURNER_BYPASS_EN (same-cycle pass-through of a
// read arriving at an empty head slot).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_type/in_data/in_index  returned request
//   rd_valid/rd_ready/rd_data/rd_index in-order read data handshake
//   wr_done/wr_index                write completion pulse and its index
//   pending                         read entries stored, not yet delivered
//   dup_err                         sticky: read hit an occupied slot
module returner
   import types_def::*;
#(
   parameter int unsigned DATA_WIDTH = data_width,
   parameter int unsigned IDX_W      = read_entries_log
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  r_type                 in_type,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [IDX_W-1:0]      in_index,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [IDX_W-1:0]      rd_index,
   output logic                  wr_done,
   output logic [IDX_W-1:0]      wr_index,
   output logic [IDX_W:0]        pending,
   output logic                  dup_err
);

   localparam int unsigned DEPTH = 2**IDX_W;

   logic [IDX_W-1:0]      head_q;
   logic [DEPTH-1:0]      occ;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  rd_arr;
   logic                  occ_head;
   logic                  slot_busy;
   logic                  byp;
   logic                  deq;
   logic                  store;
   logic                  clr;

   returner_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (store),
      .wr_idx    (in_index),
      .wr_data   (in_data),
      .clr_en    (clr),
      .head      (head_q),
      .head_data (head_data),
      .occ       (occ)
   );

   // Arrival classification, head presentation and dequeue decode.
   always_comb begin
      rd_arr    = in_valid && (in_type == read);
      occ_head  = occ[head_q];
      slot_busy = occ[in_index];
`ifdef RETURNER_BYPASS_EN
      byp       = rd_arr && (in_index == head_q) && !occ_head;
`else
      byp       = 1'b0;
`endif
      rd_valid  = occ_head || byp;
      rd_data   = byp ? in_data : head_data;
      rd_index  = head_q;
      deq       = rd_valid && rd_ready;
      // A bypassed entry consumed this cycle is never written to storage.
      store     = rd_arr && !slot_busy && !(byp && rd_ready);
      clr       = deq && occ_head;
   end

   // Head pointer, occupancy count, write ack and sticky duplicate flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q   <= '0;
         pending  <= '0;
         wr_done  <= 1'b0;
         wr_index <= '0;
         dup_err  <= 1'b0;
      end else begin
         if (deq) head_q <= head_q + IDX_W'(1);
         case ({store, clr})
            2'b10:   pending <= pending + (IDX_W+1)'(1);
            2'b01:   pending <= pending - (IDX_W+1)'(1);
            default: pending <= pending;
         endcase
         wr_done <= in_valid && (in_type == write);
         if (in_valid && (in_type == write)) wr_index <= in_index;
         if (rd_arr && slot_busy) dup_err <= 1'b1;
      end
   end

endmodule : returner

// File: doc/returner.md
# returner

Collects completed requests from `burst_handler` and hands them back to the front end. Write completions are acknowledged immediately. Read data, which arrives in burst order rather than request order, is held in an index-addressed reorder buffer. Reads are released strictly in ascending `index` order (modulo buffer depth) over a valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, default `types_def::data_width`: read data width.
- IDX_W, default `types_def::read_entries_log`: request index width; buffer depth `DEPTH = 2**IDX_W`.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  one returned request this cycle (from burst_handler `returner_valid`).
- in_type  in  r_type  `read` or `write`.
- in_data  in  DATA_WIDTH  read data; ignored for writes.
- in_index  in  IDX_W  request index assigned by the front end.
- rd_valid  out  1  in-order read data available.
- rd_ready  in  1  front end accepts read data.
- rd_data  out  DATA_WIDTH  read data at head.
- rd_index  out  IDX_W  index of data at head; always equals head pointer.
- wr_done  out  1  one-cycle pulse: write completed.
- wr_index  out  IDX_W  index of completed write, valid with wr_done.
- pending  out  IDX_W+1  number of read entries stored and not yet delivered.
- dup_err  out  1  sticky: read arrived for an already-occupied slot.

## Operation
- Storage: `DEPTH` entries of {data, occ}; head pointer `head` (IDX_W bits).
- Read arrival (in_valid, in_type==read): if `occ[in_index]==0`, write data and set occ. If occ already set, drop the data, set dup_err, and leave the entry untouched.
- Write arrival (in_valid, in_type==write): register `wr_done<=1` and `wr_index<=in_index`. The buffer is not touched.
- Output: `rd_valid = occ[head]`, `rd_data = data[head]`, `rd_index = head`.
- Dequeue (rd_valid & rd_ready): clear `occ[head]`. Increment head with natural wrap from DEPTH-1 to 0.
- pending: +1 on an accepted read arrival, −1 on dequeue, unchanged when both or neither occur. Range 0..DEPTH. It never wraps because an accepted arrival always targets a free slot.
- Same-slot collision: a read arrival at `head` while `occ[head]` is set and being dequeued in the same cycle counts as a duplicate (dup_err). The arrival is compared against the pre-edge occ.
- An arrival at `in_index != head` while the head is empty is stored. It waits; rd_valid stays low until the head slot fills.
- dup_err clears only on reset.

## Timing
- Reset (rst_n==0 at posedge): head=0, all occ=0, pending=0, rd_valid=0, wr_done=0, wr_index=0, dup_err=0. rd_data is don't-care; it is driven from storage, and storage data is not reset.
- Reset mid-operation discards all buffered data. No completions are reported afterwards for pre-reset requests.
- Read latency without the bypass (see Configuration): a read arrival in cycle N with index==head gives rd_valid=1 in cycle N+1.
- Write latency: arrival in cycle N gives wr_done=1 in cycle N+1 for exactly one cycle.
- rd_valid never deasserts without a handshake. rd_data and rd_index stay stable while rd_valid & !rd_ready.
- Back-to-back dequeues run at one entry per cycle when consecutive slots are occupied.

## Configuration
- `RETURNER_BYPASS_EN` defined: a read arrival with `in_index==head` and `occ[head]==0` appears combinationally on rd_valid, rd_data and rd_index in the same cycle.
  - If rd_ready is high that cycle, the entry is consumed: nothing is stored, head increments, and pending is unchanged.
  - If rd_ready is low, the entry is stored normally.
- Not defined: no combinational path from in_* to rd_*. Read latency is fixed at 1 cycle.

## Structure
- `types_def` package (shared): `r_type`, `data_width`, `read_entries_log`. No new package types are needed.
- One sub-module, `returner_buffer`: DEPTH×DATA_WIDTH storage with one write port and one asynchronous read port at head, plus the occ vector.
- Head, pending, the write-ack register and the error logic live in `returner`.

## Test plan
- Reset, then read arrival index 0 with data 0xA5A5 and rd_ready=1 → rd_valid one cycle later with rd_data=0xA5A5 and rd_index=0; then head=1 and pending=0.
- Out of order: reads arrive for index 2, then 1, then 0, with rd_ready=1 → outputs in order 0, 1, 2 on consecutive cycles; pending peaks at 3.
- Backpressure: fill indices 0..3 with rd_ready=0 → rd_valid held with rd_index=0 and data stable; pending=4. Raise rd_ready → four dequeues in four cycles.
- Write arrival index 5 → wr_done pulse for 1 cycle with wr_index=5; rd_valid and pending unaffected.
- Wrap and duplicate: run head through DEPTH-1 back to 0. Then send index 0 twice before dequeue → second arrival sets dup_err; the stored data is the first arrival's.
- With RETURNER_BYPASS_EN: read at index==head, slot empty, rd_ready=1 → rd_valid in the same cycle; pending stays 0.
